// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, PC step,
// FSM state encoding and the prefetch queue entry layout.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned PC_STEP = 2;

  // IDLE: no request; WAIT: request outstanding; DISCARD: outstanding, data dropped
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // One prefetched instruction together with the address it came from
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {instr, pc}, synchronous flush, head
// presented combinationally from storage, occupancy count output.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   flush       - empty the queue this cycle (push/pop ignored)
//   push        - write push_data at the tail
//   push_data   - entry to write
//   pop         - drop the head entry (ignored while empty)
//   head        - head entry
//   head_valid  - queue not empty
//   count       - current occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic               head_valid,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one halfword read at a time to instruction
// memory, buffers returned instructions in a prefetch queue, and handles
// redirects (jumps/taken branches) by flushing and refetching.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   imem_req/imem_addr      - read request and its halfword byte address
//   imem_ack/imem_rdata     - request accepted, data valid this cycle
//   redirect/redirect_pc    - flush the queue and restart fetch at redirect_pc
//   instr_valid/instr/instr_pc - queue head and its address
//   instr_ready             - datapath consumes the head this cycle
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e       state;
  fetch_state_e       state_n;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  fetch_pc_n;
  logic [ADDR_W-1:0]  addr_n;
  logic               req_n;
  logic               push;
  logic               pop;
  logic               room;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_n;
  logic               head_valid;
  fetch_entry_t       head;
  fetch_entry_t       push_data;
  logic [ADDR_W-1:0]  redirect_tgt;
  logic               redirect_lsb_unused;

  // Instructions are halfword aligned; the low address bit is discarded
  assign redirect_tgt        = {redirect_pc[ADDR_W-1:1], 1'b0};
  assign redirect_lsb_unused = redirect_pc[0];

  assign push_data.instr = imem_rdata;
  assign push_data.pc    = imem_addr;

  // Next-state, queue control and request generation
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = imem_addr;
    req_n      = imem_req;
    push       = 1'b0;
    pop        = 1'b0;
    count_n    = count;
    room       = 1'b0;

    // Only a live (non-discarded) request delivers data; a redirect drops it
    push = imem_req && imem_ack && (state == WAIT) && !redirect;
    pop  = head_valid && instr_ready && !redirect;

    // Occupancy after this cycle decides whether another request fits
    if (redirect) begin
      count_n = '0;
    end else begin
      count_n = count + CNT_W'(push) - CNT_W'(pop);
    end
    room = (count_n < CNT_W'(DEPTH));

    if (redirect) begin
      fetch_pc_n = redirect_tgt;
    end else if (push) begin
      fetch_pc_n = fetch_pc + ADDR_W'(PC_STEP);
    end

    case (state)
      IDLE: begin
        if (room) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_n = room ? WAIT : IDLE;
        end else if (redirect) begin
          state_n = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A fresh request latches its address; an outstanding one holds it until ack
    req_n = (state_n != IDLE);
    if ((state_n == WAIT) && ((state != WAIT) || imem_ack)) begin
      addr_n = fetch_pc_n;
    end
  end

  // State, PC and request registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign instr_valid = head_valid;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  logic [15:0] popq[$];
  logic [15:0] exp_pc = RESET_PC;
  bit          tainted = 1'b0;
  bit          prev_rst_low = 1'b1;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_addr = '0;
  int          acc_cnt = 0;
  int          idle_acc = 0;

  // Memory responder state
  bit pend = 1'b0;
  int lat = 0;
  int waited = 0;

  // Stimulus knobs
  int          fix_lat = 0;
  int          slow_addr = -1;
  int          slow_lat = 0;
  int          ready_pct = 100;
  int          redir_pct = 0;
  int          reset_pml = 0;
  bit          hold_reset = 1'b0;
  bit          redir_now = 1'b0;
  logic [15:0] redir_pc_k = '0;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return (a ^ 16'h5A5A) + 16'h0103;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare registered DUT outputs against the model, just after the edge
  task automatic sample();
    @(posedge clk);
    #1;
    if (prev_rst_low) begin
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_instr_pc", instr_pc, 16'h0000);
    end else begin
      chk("valid", instr_valid, (q.size() != 0));
      if (q.size() != 0) begin
        chk("instr", instr, q[0].instr);
        chk("instr_pc", instr_pc, q[0].pc);
      end
      if (prev_hold) begin
        chk("req_hold", imem_req, 1'b1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      chk("occupancy", ((q.size() + (imem_req ? 1 : 0)) <= int'(DEPTH)), 1'b1);
    end
  endtask

  // Drive this cycle's inputs, then advance the model by this cycle's events
  task automatic drive();
    bit acc;
    bit keep;
    bit pop_ok;
    rst_n = !(hold_reset || ($urandom_range(0, 999) < reset_pml));

    if (imem_req && !pend) begin
      pend   = 1'b1;
      waited = 0;
      if (int'(imem_addr) == slow_addr) lat = slow_lat;
      else if (fix_lat >= 0)            lat = fix_lat;
      else                              lat = $urandom_range(0, 3);
    end
    imem_ack    = imem_req && pend && (waited == lat);
    imem_rdata  = imem_ack ? mem_data(imem_addr) : 16'($urandom);
    redirect    = redir_now || ($urandom_range(0, 99) < redir_pct);
    redirect_pc = redir_now ? redir_pc_k : 16'($urandom);
    instr_ready = ($urandom_range(0, 99) < ready_pct);

    prev_rst_low = !rst_n;
    prev_hold    = rst_n && imem_req && !imem_ack;
    prev_addr    = imem_addr;

    if (!rst_n) begin
      q.delete();
      exp_pc   = RESET_PC;
      tainted  = 1'b0;
      pend     = 1'b0;
      idle_acc = 0;
    end else begin
      acc = imem_req && imem_ack;
      if (acc && !tainted) chk("fetch_addr", imem_addr, exp_pc);
      keep   = acc && !tainted && !redirect;
      pop_ok = (q.size() != 0) && instr_ready && !redirect;
      if (acc) begin
        acc_cnt++;
        idle_acc = 0;
        pend     = 1'b0;
      end else begin
        idle_acc++;
        if (pend) waited++;
      end
      if (redirect) begin
        q.delete();
        exp_pc = {redirect_pc[15:1], 1'b0};
      end else begin
        if (pop_ok) begin
          popq.push_back(q[0].pc);
          void'(q.pop_front());
        end
        if (keep) begin
          q.push_back('{instr: mem_data(imem_addr), pc: imem_addr});
          exp_pc = exp_pc + 16'd2;
        end
      end
      if (acc) tainted = 1'b0;
      if (redirect && imem_req && !imem_ack) tainted = 1'b1;
    end
  endtask

  task automatic cycle();
    sample();
    drive();
  endtask

  task automatic do_reset();
    hold_reset = 1'b1;
    cycle();
    hold_reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0;
    int run;
    bit found;
    logic [15:0] wrap_exp [4];
    wrap_exp[0] = 16'hFFFC;
    wrap_exp[1] = 16'hFFFE;
    wrap_exp[2] = 16'h0000;
    wrap_exp[3] = 16'h0002;

    // Streaming after reset with zero-latency memory
    fix_lat = 0; ready_pct = 100;
    do_reset();
    sample();
    chk("A_rst_req", imem_req, 1'b0);
    chk("A_rst_valid", instr_valid, 1'b0);
    drive();
    sample();
    chk("A_first_req", imem_req, 1'b1);
    chk("A_first_addr", imem_addr, RESET_PC);
    drive();
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("A_valid", instr_valid, 1'b1);
      chk("A_instr_pc", instr_pc, 16'(2 * k));
      chk("A_addr", imem_addr, 16'(2 * k + 2));
      drive();
    end

    // Stalled consumer fills the queue then stops requesting
    ready_pct = 0;
    do_reset();
    cycle();
    acc0 = acc_cnt;
    repeat (10) cycle();
    chk("B_accepted", acc_cnt - acc0, 4);
    sample();
    chk("B_req_off", imem_req, 1'b0);
    chk("B_head_pc", instr_pc, 16'h0000);
    drive();

    // Slow ack holds the request stable
    ready_pct = 100; slow_addr = 6; slow_lat = 3;
    do_reset();
    cycle();
    run = 0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (imem_req && imem_addr == 16'h0006) run++;
      drive();
    end
    chk("C_hold_cycles", run, 4);

    // Redirect while a request is outstanding
    slow_addr = 8; slow_lat = 3;
    do_reset();
    cycle();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (imem_req && imem_addr == 16'h0008) begin
        redir_now = 1'b1; redir_pc_k = 16'h0041;
        drive();
        redir_now = 1'b0;
        found = 1'b1;
        break;
      end
      drive();
    end
    chk("D_req8_seen", found, 1'b1);
    sample();
    chk("D_flushed", instr_valid, 1'b0);
    drive();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (imem_req && imem_addr != 16'h0008) begin
        chk("D_next_addr", imem_addr, 16'h0040);
        found = 1'b1;
        drive();
        break;
      end
      drive();
    end
    chk("D_next_req_seen", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (instr_valid) begin
        chk("D_next_instr_pc", instr_pc, 16'h0040);
        found = 1'b1;
        drive();
        break;
      end
      drive();
    end
    chk("D_next_instr_seen", found, 1'b1);
    slow_addr = -1;

    // Address wrap past 16'hFFFE
    sample();
    redir_now = 1'b1; redir_pc_k = 16'hFFFC;
    drive();
    redir_now = 1'b0;
    popq.delete();
    for (int i = 0; i < 30 && popq.size() < 4; i++) cycle();
    chk("E_pops", (popq.size() >= 4), 1'b1);
    if (popq.size() >= 4) begin
      for (int j = 0; j < 4; j++) chk("E_wrap_pc", popq[j], wrap_exp[j]);
    end

    // Reset pulse with a full-ish queue and a request outstanding
    ready_pct = 0; slow_addr = 6; slow_lat = 8;
    do_reset();
    cycle();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (imem_req && imem_addr == 16'h0006) begin
        chk("F_model_depth", q.size(), 3);
        chk("F_head_pc", instr_pc, 16'h0000);
        hold_reset = 1'b1;
        drive();
        hold_reset = 1'b0;
        found = 1'b1;
        break;
      end
      drive();
    end
    chk("F_req6_seen", found, 1'b1);
    sample();
    chk("F_valid_cleared", instr_valid, 1'b0);
    chk("F_req_cleared", imem_req, 1'b0);
    drive();
    sample();
    chk("F_restart_req", imem_req, 1'b1);
    chk("F_restart_addr", imem_addr, RESET_PC);
    drive();
    slow_addr = -1;

    // Randomized traffic
    fix_lat = -1; ready_pct = 70; redir_pct = 4; reset_pml = 3;
    repeat (3000) begin
      sample();
      chk("progress", (idle_acc < 200), 1'b1);
      drive();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
